// File: rtl/round_timer_if.sv
// Round timer control/status bundle.
// master: game-control side (drives commands); slave: timer side.
interface round_timer_if #(
  parameter int WIDTH = 26
);
  logic [WIDTH-1:0] target;
  logic             load;
  logic             start;
  logic             pause;
  logic             abort;
  logic             periodic;
  logic             running;
  logic             paused;
  logic             hit_target;
  logic             done_pulse;
  logic [WIDTH-1:0] remaining;

  modport master (
    output target, load, start, pause, abort, periodic,
    input  running, paused, hit_target, done_pulse, remaining
  );

  modport slave (
    input  target, load, start, pause, abort, periodic,
    output running, paused, hit_target, done_pulse, remaining
  );
endinterface

// File: rtl/round_timer.sv
// Programmable, pausable, retriggerable round timer.
// Ports: clk, reset (sync, active-high), tmr (round_timer_if.slave).
module round_timer #(
  parameter int          WIDTH          = 26,
  parameter int unsigned DEFAULT_TARGET = 46875000
) (
  input  logic        clk,
  input  logic        reset,
  round_timer_if.slave tmr
);

  localparam logic [WIDTH-1:0] DEF_T = DEFAULT_TARGET[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] eff_t;
  logic             term;

  // A zero target behaves as a one-cycle period.
  assign eff_t = (tgt_q == '0) ? ONE : tgt_q;
  assign term  = (cnt_q == eff_t - ONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= DEF_T;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (tmr.load) tgt_d = tmr.target;
        if (tmr.abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (tmr.start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN, PAUSE: begin
        if (tmr.abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (tmr.start) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (tmr.pause) begin
          // Frozen: no increment and no terminal detection.
          state_d = PAUSE;
        end else if (term) begin
          // The release cycle counts like a RUN cycle, so the
          // period grows by exactly the number of paused cycles.
          state_d = tmr.periodic ? RUN : DONE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          state_d = RUN;
          cnt_d   = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    tmr.remaining = eff_t - cnt_q;
    unique case (state_q)
      IDLE:    tmr.remaining = eff_t;
      DONE:    tmr.remaining = '0;
      default: tmr.remaining = eff_t - cnt_q;
    endcase
  end

  assign tmr.running    = (state_q == RUN);
  assign tmr.paused     = (state_q == PAUSE);
  assign tmr.hit_target = (state_q == IDLE) || (state_q == DONE);
  assign tmr.done_pulse = done_q;

endmodule

// File: tb/tb_round_timer.sv
// Directed testbench for round_timer.
// WIDTH=6, DEFAULT_TARGET=30.
module tb_round_timer;

  localparam int W = 6;

  logic clk = 1'b0;
  logic reset;

  int n_cmp = 0;
  int n_err = 0;

  round_timer_if #(.WIDTH(W)) tif ();

  round_timer #(
    .WIDTH          (W),
    .DEFAULT_TARGET (30)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .tmr   (tif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int bad;
  int pulses;
  int drops;
  int k;

  initial begin
    reset        = 1'b1;
    tif.target   = '0;
    tif.load     = 1'b0;
    tif.start    = 1'b0;
    tif.pause    = 1'b0;
    tif.abort    = 1'b0;
    tif.periodic = 1'b0;

    // 1: reset, one-shot 30-cycle round, DONE hold
    repeat (5) step();
    chk("rst_running", 32'(tif.running), 0);
    chk("rst_paused", 32'(tif.paused), 0);
    chk("rst_hit", 32'(tif.hit_target), 1);
    chk("rst_remaining", 32'(tif.remaining), 30);
    chk("rst_done", 32'(tif.done_pulse), 0);

    reset     = 1'b0;
    tif.start = 1'b1;
    step();
    tif.start = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (!tif.running || tif.done_pulse || 32'(tif.remaining) != 30 - i)
        bad++;
      step();
    end
    chk("t1_run", bad, 0);
    chk("t1_done_pulse", 32'(tif.done_pulse), 1);
    chk("t1_hit", 32'(tif.hit_target), 1);
    chk("t1_rem0", 32'(tif.remaining), 0);
    chk("t1_running", 32'(tif.running), 0);
    bad = 0;
    repeat (50) begin
      step();
      if (!tif.hit_target || tif.running || tif.done_pulse || tif.remaining != 0)
        bad++;
    end
    chk("t1_hold", bad, 0);

    // 2: periodic target 5
    tif.abort = 1'b1;
    step();
    tif.abort = 1'b0;
    chk("t2_idle_rem", 32'(tif.remaining), 30);
    tif.target   = 6'd5;
    tif.load     = 1'b1;
    tif.start    = 1'b1;
    tif.periodic = 1'b1;
    step();
    tif.load  = 1'b0;
    tif.start = 1'b0;
    chk("t2_new_t", 32'(tif.remaining), 5);
    pulses = 0;
    drops  = 0;
    bad    = 0;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (!tif.running) drops++;
      if (tif.done_pulse) begin
        pulses++;
        if (j % 5 != 0 || tif.remaining != 5) bad++;
      end
    end
    chk("t2_pulses", pulses, 4);
    chk("t2_drops", drops, 0);
    chk("t2_pulse_pos", bad, 0);
    tif.abort = 1'b1;
    step();
    tif.abort = 1'b0;
    chk("t2_abort_run", 32'(tif.running), 0);
    chk("t2_abort_rem", 32'(tif.remaining), 5);
    tif.periodic = 1'b0;

    // 3: pause 10 cycles at cnt=12
    tif.target = 6'd30;
    tif.load   = 1'b1;
    step();
    tif.load = 1'b0;
    chk("t3_idle_rem", 32'(tif.remaining), 30);
    tif.start = 1'b1;
    step();
    tif.start = 1'b0;
    repeat (12) step();
    chk("t3_rem12", 32'(tif.remaining), 18);
    tif.pause = 1'b1;
    bad = 0;
    repeat (10) begin
      step();
      if (!tif.paused || tif.running || tif.remaining != 18) bad++;
    end
    chk("t3_frozen", bad, 0);
    tif.pause = 1'b0;
    k = 0;
    while (!tif.done_pulse && k < 100) begin
      step();
      k++;
    end
    chk("t3_pulse_at", 22 + k, 40);

    // 4: retrigger on terminal cycle; load ignored in RUN
    tif.start = 1'b1;
    step();
    tif.start = 1'b0;
    repeat (29) step();
    chk("t4_term_rem", 32'(tif.remaining), 1);
    tif.start  = 1'b1;
    tif.load   = 1'b1;
    tif.target = 6'd7;
    step();
    tif.start = 1'b0;
    tif.load  = 1'b0;
    chk("t4_no_pulse", 32'(tif.done_pulse), 0);
    chk("t4_restart_rem", 32'(tif.remaining), 30);
    bad = 0;
    for (int i = 1; i < 30; i++) begin
      step();
      if (!tif.running || tif.done_pulse || 32'(tif.remaining) != 30 - i)
        bad++;
    end
    chk("t4_full_run", bad, 0);
    step();
    chk("t4_end_pulse", 32'(tif.done_pulse), 1);

    // 5: zero target, abort beats start
    tif.target = '0;
    tif.load   = 1'b1;
    step();
    tif.load = 1'b0;
    chk("t5_done_rem", 32'(tif.remaining), 0);
    tif.start = 1'b1;
    step();
    tif.start = 1'b0;
    chk("t5_run1", 32'(tif.running), 1);
    chk("t5_rem1", 32'(tif.remaining), 1);
    step();
    chk("t5_pulse", 32'(tif.done_pulse), 1);
    chk("t5_hit", 32'(tif.hit_target), 1);
    tif.start = 1'b1;
    step();
    chk("t5_rerun", 32'(tif.running), 1);
    tif.abort = 1'b1;
    step();
    tif.abort = 1'b0;
    tif.start = 1'b0;
    chk("t5_abort_win", 32'(tif.running), 0);
    chk("t5_abort_rem", 32'(tif.remaining), 1);
    chk("t5_abort_pulse", 32'(tif.done_pulse), 0);

    // 6: load+start together, then reset mid-run
    tif.target = 6'd20;
    tif.load   = 1'b1;
    tif.start  = 1'b1;
    step();
    tif.load  = 1'b0;
    tif.start = 1'b0;
    chk("t6_new_t", 32'(tif.remaining), 20);
    repeat (15) step();
    chk("t6_rem15", 32'(tif.remaining), 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_hit", 32'(tif.hit_target), 1);
    chk("t6_rem", 32'(tif.remaining), 30);
    chk("t6_done", 32'(tif.done_pulse), 0);
    chk("t6_running", 32'(tif.running), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
